// File: rtl/bounce_pkg.sv
// Shared constants, move classification and distance helper for the bounce controller.
package bounce_pkg;

  // Width of the downstream up/down counter value.
  localparam int unsigned CNT_W = 4;

  // Speed encodings as driven on the counter's step input.
  localparam logic SPD_SLOW = 1'b0;  // move by 1
  localparam logic SPD_FAST = 1'b1;  // move by 2

  // What the controller does with the counter on a given cycle.
  typedef enum logic [2:0] {
    MvSeekUp,    // below window: climb back in
    MvSeekDown,  // above window: descend back in
    MvUp,        // in window, sweeping up
    MvTurnDown,  // sitting on hi while sweeping up: reverse
    MvDown,      // in window, sweeping down
    MvTurnUp     // sitting on lo while sweeping down: reverse, one round trip done
  } move_e;

  // True when a - b >= 2; callers guarantee a >= b so the difference never wraps.
  function automatic logic dist_ge2(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] d;
    d = a - b;
    return d >= CNT_W'(2);
  endfunction

endpackage

// File: rtl/bounce_decide.sv
// Combinational move decision: classifies the counter value against the window and
// direction, then picks step/down and the next direction/seek state.
module bounce_decide
  import bounce_pkg::*;
(
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  input  logic             dir_up,
  input  logic             fast,      // speed in force for ordinary sweep moves
  input  logic             fsp,       // speed to use if this cycle is a reversal
  output logic             step,
  output logic             down,
  output logic             dir_nxt,
  output logic             seek_nxt,
  output logic             rev_top,
  output logic             rev_bot
);

  move_e move;

  // Classify the cycle; out-of-window always wins over the sweep direction.
  always_comb begin
    if (cnt < lo) begin
      move = MvSeekUp;
    end else if (cnt > hi) begin
      move = MvSeekDown;
    end else if (dir_up) begin
      move = (cnt == hi) ? MvTurnDown : MvUp;
    end else begin
      move = (cnt == lo) ? MvTurnUp : MvDown;
    end
  end

  // Drive the counter; a double step is only taken when two units of room remain,
  // so a bound is never overshot and the counter never wraps.
  always_comb begin
    step     = 1'b0;
    down     = 1'b0;
    dir_nxt  = dir_up;
    seek_nxt = 1'b0;
    rev_top  = 1'b0;
    rev_bot  = 1'b0;
    unique case (move)
      MvSeekUp: begin
        step     = dist_ge2(lo, cnt);
        seek_nxt = 1'b1;
        dir_nxt  = 1'b1;
      end
      MvSeekDown: begin
        down     = 1'b1;
        step     = dist_ge2(cnt, hi);
        seek_nxt = 1'b1;
        dir_nxt  = 1'b0;
      end
      MvUp: begin
        step = (fast == SPD_FAST) && dist_ge2(hi, cnt);
      end
      MvTurnDown: begin
        down    = 1'b1;
        step    = (fsp == SPD_FAST) && dist_ge2(cnt, lo);
        dir_nxt = 1'b0;
        rev_top = 1'b1;
      end
      MvDown: begin
        down = 1'b1;
        step = (fast == SPD_FAST) && dist_ge2(cnt, lo);
      end
      MvTurnUp: begin
        step    = (fsp == SPD_FAST) && dist_ge2(hi, cnt);
        dir_nxt = 1'b1;
        rev_bot = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bounce_ctrl.sv
// Upstream controller that ping-pongs a 4-bit up/down counter inside [lo, hi].
// Holds direction/seek/speed/period state, legalises the window and runs the
// speed-change handshake; the per-cycle move comes from bounce_decide.
module bounce_ctrl
  import bounce_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  input  logic             spd_req,
  input  logic             spd_val,
  output logic             spd_ack,
  output logic             step,
  output logic             down,
  output logic             dir_up,
  output logic             seeking,
  output logic             cfg_err,
  output logic [PW-1:0]    periods
);

  logic          dir_q, dir_d;
  logic          seek_q, seek_d;
  logic          fast_q, fast_d;
  logic [PW-1:0] periods_q, periods_d;

  logic [CNT_W-1:0] win_lo, win_hi;
  logic             fsp;
  logic             dec_step, dec_down, dir_nxt, seek_nxt, rev_top, rev_bot;

  // An empty or inverted window falls back to the full counter range.
  always_comb begin
    cfg_err = !(lo < hi);
    win_lo  = cfg_err ? '0 : lo;
    win_hi  = cfg_err ? '1 : hi;
  end

  // A pending request takes effect on the reversal it coincides with.
  assign fsp = spd_req ? spd_val : fast_q;

  bounce_decide u_decide (
    .cnt      (cnt),
    .lo       (win_lo),
    .hi       (win_hi),
    .dir_up   (dir_q),
    .fast     (fast_q),
    .fsp      (fsp),
    .step     (dec_step),
    .down     (dec_down),
    .dir_nxt  (dir_nxt),
    .seek_nxt (seek_nxt),
    .rev_top  (rev_top),
    .rev_bot  (rev_bot)
  );

  // Outputs and next state; the counter is held still while reset is asserted.
  always_comb begin
    step      = 1'b0;
    down      = 1'b0;
    spd_ack   = 1'b0;
    dir_d     = dir_q;
    seek_d    = seek_q;
    fast_d    = fast_q;
    periods_d = periods_q;
    if (!rst) begin
      step   = dec_step;
      down   = dec_down;
      dir_d  = dir_nxt;
      seek_d = seek_nxt;
      if ((rev_top || rev_bot) && spd_req) begin
        spd_ack = 1'b1;
        fast_d  = spd_val;
      end
      if (rev_bot) begin
        periods_d = periods_q + PW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= 1'b1;
      seek_q    <= 1'b0;
      fast_q    <= SPD_SLOW;
      periods_q <= '0;
    end else begin
      dir_q     <= dir_d;
      seek_q    <= seek_d;
      fast_q    <= fast_d;
      periods_q <= periods_d;
    end
  end

  assign dir_up  = dir_q;
  assign seeking = seek_q;
  assign periods = periods_q;

endmodule

// File: tb/tb_bounce_ctrl.sv
// Directed bench: a behavioural 4-bit counter closes the loop around bounce_ctrl;
// expected counter values, acks and seek flags are queued and compared per cycle.
module tb_bounce_ctrl;
  import bounce_pkg::*;

  typedef struct {
    logic [3:0] cnt;
    logic       ack;
    logic       seek;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] cnt;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       spd_req;
  logic       spd_val;
  logic       spd_ack;
  logic       step;
  logic       down;
  logic       dir_up;
  logic       seeking;
  logic       cfg_err;
  logic [7:0] periods;

  exp_t        exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  bounce_ctrl #(.PW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .cnt     (cnt),
    .lo      (lo),
    .hi      (hi),
    .spd_req (spd_req),
    .spd_val (spd_val),
    .spd_ack (spd_ack),
    .step    (step),
    .down    (down),
    .dir_up  (dir_up),
    .seeking (seeking),
    .cfg_err (cfg_err),
    .periods (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The controlled counter: reset to 0, then moves by 1 or 2 every clock.
  always @(posedge clk) begin
    if (rst) cnt <= 4'd0;
    else if (down) cnt <= cnt - (step ? 4'd2 : 4'd1);
    else cnt <= cnt + (step ? 4'd2 : 4'd1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic a, input logic s);
    exp_t e;
    e.cnt  = 4'(c);
    e.ack  = a;
    e.seek = s;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; compares one queued entry per cycle, then advances.
  task automatic drain(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_cnt"}, 32'(cnt), 32'(e.cnt));
      chk({tag, "_ack"}, 32'(spd_ack), 32'(e.ack));
      chk({tag, "_seek"}, 32'(seeking), 32'(e.seek));
      @(posedge clk);
      #1;
      if (e.ack) spd_req = 1'b0;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; holds reset for two clocks and checks the reset state.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_down", 32'(down), 32'd0);
    chk("rst_ack", 32'(spd_ack), 32'd0);
    @(negedge clk);
    chk("rst_periods", 32'(periods), 32'd0);
    chk("rst_dir", 32'(dir_up), 32'd1);
    chk("rst_seek", 32'(seeking), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lo = 4'd2; hi = 4'd9; spd_req = 1'b0; spd_val = 1'b0;

    // Slow bounce in [2,9] from 0, one seek cycle, one round trip.
    do_reset();
    chk("t1_cfg", 32'(cfg_err), 32'd0);
    push(0, 0, 0); push(2, 0, 1);
    for (int v = 3; v <= 9; v++) push(v, 0, 0);
    for (int v = 8; v >= 2; v--) push(v, 0, 0);
    push(3, 0, 0);
    drain("t1");
    chk("t1_periods", 32'(periods), 32'd1);
    chk("t1_dir", 32'(dir_up), 32'd1);

    // Fast request held from reset, acked at the first reversal (12).
    lo = 4'd3; hi = 4'd12; spd_req = 1'b1; spd_val = 1'b1;
    do_reset();
    push(0, 0, 0); push(2, 0, 1); push(3, 0, 1);
    for (int v = 4; v <= 11; v++) push(v, 0, 0);
    push(12, 1, 0);
    for (int v = 10; v >= 4; v -= 2) push(v, 0, 0);
    push(3, 0, 0);
    for (int v = 5; v <= 11; v += 2) push(v, 0, 0);
    push(12, 0, 0); push(10, 0, 0);
    drain("t2");
    chk("t2_dir", 32'(dir_up), 32'd0);

    // Go fast, then request slow mid-sweep at 6: ack only at 13.
    lo = 4'd2; hi = 4'd13; spd_req = 1'b1; spd_val = 1'b1;
    do_reset();
    push(0, 0, 0); push(2, 0, 1);
    for (int v = 3; v <= 12; v++) push(v, 0, 0);
    push(13, 1, 0);
    for (int v = 11; v >= 3; v -= 2) push(v, 0, 0);
    push(2, 0, 0); push(4, 0, 0);
    drain("t3a");
    spd_req = 1'b1; spd_val = 1'b0;
    for (int v = 6; v <= 12; v += 2) push(v, 0, 0);
    push(13, 1, 0); push(12, 0, 0); push(11, 0, 0); push(10, 0, 0);
    drain("t3b");
    chk("t3_dir", 32'(dir_up), 32'd0);

    // Inverted window: full-range bounce with no wrap at either end.
    lo = 4'd9; hi = 4'd4; spd_req = 1'b0; spd_val = 1'b0;
    do_reset();
    chk("t4_cfg", 32'(cfg_err), 32'd1);
    for (int v = 0; v <= 15; v++) push(v, 0, 0);
    for (int v = 14; v >= 0; v--) push(v, 0, 0);
    push(1, 0, 0);
    drain("t4");
    chk("t4_periods", 32'(periods), 32'd1);

    // Window jumps to [12,14] while at 8: seek up by 2, then normal sweep.
    lo = 4'd2; hi = 4'd9;
    do_reset();
    push(0, 0, 0); push(2, 0, 1);
    for (int v = 3; v <= 7; v++) push(v, 0, 0);
    drain("t5a");
    lo = 4'd12; hi = 4'd14;
    #1;
    chk("t5_seek_step", 32'(step), 32'd1);
    chk("t5_seek_down", 32'(down), 32'd0);
    push(8, 0, 0); push(10, 0, 1); push(12, 0, 1);
    push(13, 0, 0); push(14, 0, 0); push(13, 0, 0);
    drain("t5b");
    chk("t5_cfg", 32'(cfg_err), 32'd0);

    // Five round trips in [2,4], then reset mid-sweep.
    lo = 4'd2; hi = 4'd4;
    do_reset();
    push(0, 0, 0); push(2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      push(3, 0, 0); push(4, 0, 0); push(3, 0, 0); push(2, 0, 0);
    end
    push(3, 0, 0); push(4, 0, 0); push(3, 0, 0);
    drain("t6");
    chk("t6_periods", 32'(periods), 32'd5);
    chk("t6_dir", 32'(dir_up), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_step", 32'(step), 32'd0);
    chk("t6_rst_down", 32'(down), 32'd0);
    @(negedge clk);
    chk("t6_rst_periods", 32'(periods), 32'd0);
    chk("t6_rst_dir", 32'(dir_up), 32'd1);
    chk("t6_rst_step2", 32'(step), 32'd0);
    chk("t6_rst_down2", 32'(down), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Tightest window [2,3]: 256 round trips wrap periods back to 0.
    lo = 4'd2; hi = 4'd3;
    do_reset();
    push(0, 0, 0); push(2, 0, 1);
    for (int i = 0; i < 255; i++) begin
      push(3, 0, 0); push(2, 0, 0);
    end
    drain("t7a");
    chk("t7_periods_max", 32'(periods), 32'd255);
    push(3, 0, 0); push(2, 0, 0);
    drain("t7b");
    chk("t7_periods_wrap", 32'(periods), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bounce_ctrl.md
Name: bounce_ctrl

Overview:
Upstream control stage for the team's 4-bit up/down counter (T-flip-flop based; counts every clock by ±1 or ±2; inputs step, down).
Drives the counter's step/down each cycle so its value ping-pongs inside a programmable window [lo, hi].
Observes the counter's current value and decides the next move combinationally (Mealy).
Tracks direction, out-of-window recovery, speed changes via handshake, and a round-trip count.

Parameters:
PW, 8, width of the round-trip period counter (wraps modulo 2^PW).

Ports:
clk  in  1  clock; the counter shares this clock.
rst  in  1  reset, synchronous, active-high. Top level ties the counter's active-low reset to !rst.
cnt  in  4  current counter value.
lo  in  4  window lower bound.
hi  in  4  window upper bound.
spd_req  in  1  speed-change request, level-held until ack.
spd_val  in  1  requested speed: 0 = ±1, 1 = ±2; stable while spd_req=1.
spd_ack  out  1  one-cycle pulse when the requested speed takes effect.
step  out  1  to counter: 1 = move by 2, 0 = move by 1.
down  out  1  to counter: 1 = decrement, 0 = increment.
dir_up  out  1  registered direction state.
seeking  out  1  registered; 1 while recovering into the window.
cfg_err  out  1  combinational; 1 when lo >= hi.
periods  out  PW  completed round trips.

Behaviour:
- Effective window: if lo < hi, use [lo, hi]; otherwise cfg_err=1 and use [0, 15].
- State registers: dir_up, seeking, fast (current speed), periods.
- Reset values: dir_up=1, seeking=0, fast=0, periods=0, spd_ack=0. While rst=1, step=0 and down=0 are forced.
- Decision priority, evaluated each cycle on cnt:
  1) cnt < lo: down=0; step=1 if lo-cnt >= 2, else 0. Next state: seeking=1, dir_up=1. Fast is ignored during seek.
  2) cnt > hi: down=1; step=1 if cnt-hi >= 2, else 0. Next state: seeking=1, dir_up=0.
  3) In window, dir_up=1, cnt < hi: down=0; step = fast & (hi-cnt >= 2). Next state: seeking=0.
  4) In window, dir_up=1, cnt == hi: reversal. down=1; step = f' & (cnt-lo >= 2). Next state: dir_up=0, seeking=0.
  5) Cases 3 and 4 mirror for dir_up=0, with lo as the bound. Reversal at cnt == lo: down=0; step = f' & (hi-cnt >= 2); periods increments; dir_up=1.
- Speed f' on a reversal cycle: f' = spd_val if spd_req=1, else fast.
  - On that cycle, spd_ack=1 and fast <= spd_val.
  - Speed changes occur only on reversal cycles. A request issued mid-sweep waits.
- Consequences of the rules above:
  - The counter never wraps (0 to 15 or 15 to 0).
  - It never leaves a legal window once inside.
  - It never overshoots a bound: the last step before a bound is ±1 when the remaining distance is 1.
- Reversal from seek: entering the window through case 1 or 2 continues in the seek direction. The normal rules apply from the next cycle.
- Mid-run lo/hi change: handled purely by the priority above. Out-of-window immediately triggers seek. No other recovery is required.
- periods wraps from 2^PW-1 to 0.
- spd_req asserted during rst: ignored. Ack can occur from the first post-reset reversal.

Decomposition:
- Package bounce_pkg: constant CNT_W=4; constants SPD_SLOW=0, SPD_FAST=1.
- Sub-module: bounce_decide, purely combinational. Inputs: cnt, effective lo/hi, dir_up, f'. Outputs: step, down, next dir_up, next seeking, reversal flags.
- bounce_ctrl holds the registers, window legalisation and the handshake.

Test Plan:
- rst, then lo=2, hi=9, slow, counter from 0 -> cnt sequence 0,2,3,4,...,9,8,...,2,3. periods=1 after the lo reversal; seeking=1 only in the first cycle.
- lo=3, hi=12, spd_req=1/spd_val=1 held from reset -> ack on first reversal (at 12). Then sequence 10,8,6,4,3,5,7,9,11,12; never steps past a bound.
- Fast sweep at 6 of lo=2, hi=13, then spd_req with val 0 -> no ack until cnt=13. Ack pulses exactly one cycle there; subsequent moves are ±1.
- lo=9, hi=4 -> cfg_err=1, bounce 0..15 with no wrap (15 -> 14, 0 -> 1).
- While running in [2,9] at cnt=8, change to lo=12, hi=14 -> seek up 8,10,12 with step=1, then normal up-sweep 13,14 and reversal.
- Assert rst mid-sweep with periods=5 -> next cycle periods=0, dir_up=1, step=0, down=0 during rst.
